// File: rtl/picorv32_rvfimon_pkg.sv
// Shared types and constants for the picorv32 RVFI retirement monitor.
package picorv32_rvfimon_pkg;

   typedef enum logic [2:0] {
      ERR_NONE  = 3'd0,
      ERR_ORDER = 3'd1,
      ERR_PC    = 3'd2,
      ERR_RS1   = 3'd3,
      ERR_RS2   = 3'd4,
      ERR_RD    = 3'd5,
      ERR_MEM   = 3'd6,
      ERR_HALT  = 3'd7
   } err_code_e;

   localparam int unsigned NUM_LEGAL_MASKS = 7;
   localparam logic [3:0] LEGAL_MASKS [NUM_LEGAL_MASKS] = '{
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
   };

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } shadow_rd_t;

   function automatic logic mask_legal(input logic [3:0] mask);
      logic ok;
      ok = 1'b0;
      for (int unsigned i = 0; i < NUM_LEGAL_MASKS; i++) begin
         if (mask == LEGAL_MASKS[i]) ok = 1'b1;
      end
      return ok;
   endfunction

endpackage

// File: rtl/picorv32_rvfimon_shadow_regs.sv
// Shadow copy of the architectural register file built from retired writes.
// x0 always reads as a known zero.
module picorv32_rvfimon_shadow_regs
   import picorv32_rvfimon_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output shadow_rd_t  rs1_rd,
   output shadow_rd_t  rs2_rd,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data
);

   logic [31:0] data_q [1:31];
   logic [31:0] data_d [1:31];
   logic [31:0] valid_q;
   logic [31:0] valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (wr_en && (wr_addr != 5'd0)) begin
         data_d[wr_addr]  = wr_data;
         valid_d[wr_addr] = 1'b1;
      end
   end

   // Only the valid bits need clearing; stale data is never trusted.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      if (!resetn) valid_q <= '0;
      else         valid_q <= valid_d;
   end

   always_comb begin
      rs1_rd = '{valid: 1'b1, data: '0};
      rs2_rd = '{valid: 1'b1, data: '0};
      if (rs1_addr != 5'd0) rs1_rd = '{valid: valid_q[rs1_addr], data: data_q[rs1_addr]};
      if (rs2_addr != 5'd0) rs2_rd = '{valid: valid_q[rs2_addr], data: data_q[rs2_addr]};
   end

endmodule

// File: rtl/picorv32_rvfimon.sv
// RVFI retirement monitor for picorv32_axi: checks each retired record for
// self-consistency and reports violations on registered error outputs.
module picorv32_rvfimon
   import picorv32_rvfimon_pkg::*;
#(
   parameter int STOP_ON_ERROR = 1,
   parameter int CHECK_MEM     = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rvfi_valid,
   input  logic [63:0] rvfi_order,
   input  logic [31:0] rvfi_insn,
   input  logic        rvfi_trap,
   input  logic        rvfi_halt,
   input  logic        rvfi_intr,
   input  logic [4:0]  rvfi_rs1_addr,
   input  logic [4:0]  rvfi_rs2_addr,
   input  logic [4:0]  rvfi_rd_addr,
   input  logic [31:0] rvfi_rs1_rdata,
   input  logic [31:0] rvfi_rs2_rdata,
   input  logic [31:0] rvfi_rd_wdata,
   input  logic [31:0] rvfi_pc_rdata,
   input  logic [31:0] rvfi_pc_wdata,
   input  logic [31:0] rvfi_mem_addr,
   input  logic [3:0]  rvfi_mem_rmask,
   input  logic [3:0]  rvfi_mem_wmask,
   input  logic [31:0] rvfi_mem_rdata,
   input  logic [31:0] rvfi_mem_wdata,
   output logic        err_valid,
   output logic [2:0]  err_code,
   output logic [63:0] err_order,
   output logic        err_sticky
);

   logic        have_prev_q, have_prev_d;
   logic        halted_q, halted_d;
   logic [63:0] prev_order_q, prev_order_d;
   logic [31:0] prev_pc_q, prev_pc_d;
   logic        err_valid_q, err_valid_d;
   err_code_e   err_code_q, err_code_d;
   logic [63:0] err_order_q, err_order_d;
   logic        err_sticky_q, err_sticky_d;

   shadow_rd_t  rs1_rd, rs2_rd;
   logic        shadow_we;
   err_code_e   code;
   logic        order_bad, pc_bad, rs1_bad, rs2_bad, rd_bad, mem_bad;
   logic [3:0]  any_mask;

   logic unused_inputs;
   assign unused_inputs = ^{rvfi_insn, rvfi_mem_rdata, rvfi_mem_wdata};

   assign shadow_we = rvfi_valid && !rvfi_trap && (rvfi_rd_addr != 5'd0);

   picorv32_rvfimon_shadow_regs u_shadow (
      .clk      (clk),
      .resetn   (resetn),
      .rs1_addr (rvfi_rs1_addr),
      .rs2_addr (rvfi_rs2_addr),
      .rs1_rd   (rs1_rd),
      .rs2_rd   (rs2_rd),
      .wr_en    (shadow_we),
      .wr_addr  (rvfi_rd_addr),
      .wr_data  (rvfi_rd_wdata)
   );

   // x0 reads as {valid=1, data=0}, so the zero rule needs no special case.
   always_comb begin
      any_mask  = rvfi_mem_rmask | rvfi_mem_wmask;
      order_bad = have_prev_q && (rvfi_order != prev_order_q + 64'd1);
      pc_bad    = have_prev_q && !rvfi_intr && (rvfi_pc_rdata != prev_pc_q);
      rs1_bad   = !rvfi_trap && rs1_rd.valid && (rvfi_rs1_rdata != rs1_rd.data);
      rs2_bad   = !rvfi_trap && rs2_rd.valid && (rvfi_rs2_rdata != rs2_rd.data);
      rd_bad    = !rvfi_trap && (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);
      mem_bad   = (CHECK_MEM != 0) && !rvfi_trap && (
                     ((rvfi_mem_rmask != 4'd0) && (rvfi_mem_wmask != 4'd0)) ||
                     ((rvfi_mem_rmask != 4'd0) && !mask_legal(rvfi_mem_rmask)) ||
                     ((rvfi_mem_wmask != 4'd0) && !mask_legal(rvfi_mem_wmask)) ||
                     ((any_mask != 4'd0) && (rvfi_mem_addr[1:0] != 2'b00)));

      if      (order_bad) code = ERR_ORDER;
      else if (pc_bad)    code = ERR_PC;
      else if (rs1_bad)   code = ERR_RS1;
      else if (rs2_bad)   code = ERR_RS2;
      else if (rd_bad)    code = ERR_RD;
      else if (mem_bad)   code = ERR_MEM;
      else if (halted_q)  code = ERR_HALT;
      else                code = ERR_NONE;
   end

   always_comb begin
      have_prev_d  = have_prev_q;
      halted_d     = halted_q;
      prev_order_d = prev_order_q;
      prev_pc_d    = prev_pc_q;
      err_valid_d  = rvfi_valid && (code != ERR_NONE);
      err_code_d   = err_code_q;
      err_order_d  = err_order_q;
      err_sticky_d = err_sticky_q | err_valid_d;
      if (rvfi_valid) begin
         have_prev_d  = 1'b1;
         halted_d     = halted_q | rvfi_halt;
         prev_order_d = rvfi_order;
         prev_pc_d    = rvfi_pc_wdata;
      end
      if (err_valid_d) begin
         err_code_d  = code;
         err_order_d = rvfi_order;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         have_prev_q  <= 1'b0;
         halted_q     <= 1'b0;
         prev_order_q <= '0;
         prev_pc_q    <= '0;
         err_valid_q  <= 1'b0;
         err_code_q   <= ERR_NONE;
         err_order_q  <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         have_prev_q  <= have_prev_d;
         halted_q     <= halted_d;
         prev_order_q <= prev_order_d;
         prev_pc_q    <= prev_pc_d;
         err_valid_q  <= err_valid_d;
         err_code_q   <= err_code_d;
         err_order_q  <= err_order_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign err_valid  = err_valid_q;
   assign err_code   = err_code_q;
   assign err_order  = err_order_q;
   assign err_sticky = err_sticky_q;

`ifndef SYNTHESIS
   generate
      if (STOP_ON_ERROR != 0) begin : g_stop
         always_ff @(posedge clk) begin
            if (resetn && err_valid_d && !err_sticky_q) begin
               $display("RVFI ERROR code=%0d order=%0d pc=0x%08h", code, rvfi_order, rvfi_pc_rdata);
               $stop;
            end
         end
      end
   endgenerate
`endif

endmodule

// File: tb/tb_picorv32_rvfimon.sv
// Randomized and directed bench for picorv32_rvfimon against a record-level model.
module tb_picorv32_rvfimon;

   typedef struct {
      bit          valid;
      bit [63:0]   order;
      bit          trap, halt, intr;
      bit [4:0]    rs1, rs2, rd;
      bit [31:0]   rs1d, rs2d, rdw, pcr, pcw, addr;
      bit [3:0]    rm, wm;
   } rec_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
   logic [63:0] rvfi_order;
   logic [31:0] rvfi_insn;
   logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
   logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
   logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr;
   logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
   logic [31:0] rvfi_mem_rdata, rvfi_mem_wdata;
   logic        err_valid, err_sticky;
   logic [2:0]  err_code;
   logic [63:0] err_order;

   int checks = 0;
   int failures = 0;

   // Reference state: the record history as the rules describe it.
   bit          m_have_prev, m_halted;
   bit [63:0]   m_prev_order;
   bit [31:0]   m_prev_pc;
   bit [31:0]   m_reg [32];
   bit          m_known [32];
   bit          e_valid, e_sticky;
   int          e_code;
   bit [63:0]   e_order;

   always #5 clk = ~clk;

   picorv32_rvfimon #(.STOP_ON_ERROR(0), .CHECK_MEM(1)) dut (
      .clk(clk), .resetn(resetn), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
      .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
      .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
      .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
      .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr),
      .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
      .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
      .err_valid(err_valid), .err_code(err_code), .err_order(err_order), .err_sticky(err_sticky)
   );

   function automatic bit legal_mask(input bit [3:0] m);
      return m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
   endfunction

   function automatic bit reg_mismatch(input bit [4:0] a, input bit [31:0] d);
      if (a == 0) return d != 0;
      return m_known[a] && (d != m_reg[a]);
   endfunction

   task automatic model_reset();
      m_have_prev = 0; m_halted = 0; m_prev_order = 0; m_prev_pc = 0;
      for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_known[i] = 0; end
      e_valid = 0; e_sticky = 0; e_code = 0; e_order = 0;
   endtask

   task automatic model_record(input rec_t r);
      int c;
      e_valid = 0;
      if (!r.valid) return;
      c = 0;
      if (m_halted) c = 7;
      if (!r.trap) begin
         if ((r.rm != 0 && r.wm != 0) || (r.rm != 0 && !legal_mask(r.rm)) ||
             (r.wm != 0 && !legal_mask(r.wm)) || ((r.rm | r.wm) != 0 && r.addr[1:0] != 0)) c = 6;
         if (r.rd == 0 && r.rdw != 0) c = 5;
         if (reg_mismatch(r.rs2, r.rs2d)) c = 4;
         if (reg_mismatch(r.rs1, r.rs1d)) c = 3;
      end
      if (m_have_prev && !r.intr && r.pcr != m_prev_pc) c = 2;
      if (m_have_prev && r.order != m_prev_order + 64'd1) c = 1;
      if (c != 0) begin
         e_valid = 1; e_code = c; e_order = r.order; e_sticky = 1;
      end
      if (!r.trap && r.rd != 0) begin m_reg[r.rd] = r.rdw; m_known[r.rd] = 1; end
      m_have_prev = 1; m_prev_order = r.order; m_prev_pc = r.pcw;
      if (r.halt) m_halted = 1;
   endtask

   function automatic rec_t base_rec();
      rec_t r;
      r.valid = 1; r.trap = 0; r.halt = 0; r.intr = 0;
      r.order = m_have_prev ? m_prev_order + 64'd1 : {$urandom(), $urandom()};
      r.pcr = m_have_prev ? m_prev_pc : ($urandom() & 32'hFFFF_FFFC);
      r.pcw = r.pcr + 32'd4;
      r.rs1 = 0; r.rs2 = 0; r.rd = 0; r.rs1d = 0; r.rs2d = 0; r.rdw = 0;
      r.addr = 0; r.rm = 0; r.wm = 0;
      return r;
   endfunction

   // Drive at a falling edge, let one rising edge sample it, check at the next falling edge.
   task automatic step(input rec_t r);
      rvfi_valid = r.valid; rvfi_order = r.order; rvfi_trap = r.trap; rvfi_halt = r.halt;
      rvfi_intr = r.intr; rvfi_rs1_addr = r.rs1; rvfi_rs2_addr = r.rs2; rvfi_rd_addr = r.rd;
      rvfi_rs1_rdata = r.rs1d; rvfi_rs2_rdata = r.rs2d; rvfi_rd_wdata = r.rdw;
      rvfi_pc_rdata = r.pcr; rvfi_pc_wdata = r.pcw; rvfi_mem_addr = r.addr;
      rvfi_mem_rmask = r.rm; rvfi_mem_wmask = r.wm;
      rvfi_insn = $urandom(); rvfi_mem_rdata = $urandom(); rvfi_mem_wdata = $urandom();
      @(posedge clk);
      model_record(r);
      @(negedge clk);
      rvfi_valid = 0;
      checks++;
      if (err_valid !== e_valid) begin
         failures++; $display("FAIL err_valid order=%0d got=%b want=%b", r.order, err_valid, e_valid);
      end
      if (e_valid) begin
         checks++;
         if (err_code !== 3'(e_code)) begin
            failures++; $display("FAIL err_code order=%0d got=%0d want=%0d", r.order, err_code, e_code);
         end
         checks++;
         if (err_order !== e_order) begin
            failures++; $display("FAIL err_order got=%0d want=%0d", err_order, e_order);
         end
      end
      checks++;
      if (err_sticky !== e_sticky) begin
         failures++; $display("FAIL err_sticky order=%0d got=%b want=%b", r.order, err_sticky, e_sticky);
      end
   endtask

   task automatic expect_now(input string name, input bit v, input int code);
      checks++;
      if (err_valid !== v || (v && err_code !== 3'(code))) begin
         failures++;
         $display("FAIL %s got valid=%b code=%0d want valid=%b code=%0d", name, err_valid, err_code, v, code);
      end
   endtask

   task automatic test_reset();
      resetn = 0; rvfi_valid = 0;
      @(negedge clk); @(negedge clk);
      model_reset();
      checks++;
      if (err_valid !== 1'b0 || err_code !== 3'd0 || err_order !== 64'd0 || err_sticky !== 1'b0) begin
         failures++;
         $display("FAIL reset got v=%b c=%0d o=%0d s=%b want all 0", err_valid, err_code, err_order, err_sticky);
      end
      resetn = 1;
   endtask

   task automatic test_clean_chain();
      rec_t r;
      test_reset();
      for (int i = 0; i < 3; i++) begin
         r = base_rec(); r.order = 64'(i); r.pcr = 32'(4 * i); r.pcw = 32'(4 * i + 4);
         step(r);
         expect_now("clean_chain", 0, 0);
      end
      checks++;
      if (err_sticky !== 1'b0) begin failures++; $display("FAIL clean_sticky got=%b want=0", err_sticky); end
   endtask

   task automatic test_order_gap();
      rec_t r;
      test_reset();
      r = base_rec(); r.order = 64'd5; step(r);
      expect_now("order_first", 0, 0);
      r = base_rec(); r.order = 64'd7; step(r);
      expect_now("order_gap", 1, 1);
      checks++;
      if (err_order !== 64'd7 || err_sticky !== 1'b1) begin
         failures++; $display("FAIL order_gap_fields got o=%0d s=%b want o=7 s=1", err_order, err_sticky);
      end
      r = base_rec(); r.order = 64'hFFFF_FFFF_FFFF_FFFF; step(r);
      r = base_rec(); step(r);
      expect_now("order_wrap", 0, 0);
   endtask

   task automatic test_shadow();
      rec_t r;
      r = base_rec(); r.rd = 5; r.rdw = 32'hDEADBEEF; step(r);
      r = base_rec(); r.rs1 = 5; r.rs1d = 32'h12345678; step(r);
      expect_now("rs1_mismatch", 1, 3);
      r = base_rec(); r.rs1 = 5; r.rs1d = 32'hDEADBEEF; step(r);
      expect_now("rs1_match", 0, 0);
      r = base_rec(); r.rs2 = 5; r.rs2d = 32'h0; step(r);
      expect_now("rs2_mismatch", 1, 4);
      r = base_rec(); r.rs1 = 5; r.rs1d = 32'hDEADBEEF; r.rd = 5; r.rdw = 32'h1; step(r);
      expect_now("read_before_write", 0, 0);
   endtask

   task automatic test_rd_mem();
      rec_t r;
      r = base_rec(); r.rd = 0; r.rdw = 32'h1; step(r);
      expect_now("rd_zero", 1, 5);
      r = base_rec(); r.rm = 4'b0101; step(r);
      expect_now("mem_mask", 1, 6);
      r = base_rec(); r.wm = 4'b1111; r.addr = 32'h102; step(r);
      expect_now("mem_align", 1, 6);
      r = base_rec(); r.rm = 4'b0101; r.trap = 1; step(r);
      expect_now("trap_skips_mem", 0, 0);
   endtask

   task automatic test_intr_pc();
      rec_t r;
      r = base_rec(); r.pcr = m_prev_pc + 32'h100; r.pcw = r.pcr + 4; r.intr = 1; step(r);
      expect_now("pc_intr", 0, 0);
      r = base_rec(); r.pcr = m_prev_pc + 32'h100; r.pcw = r.pcr + 4; step(r);
      expect_now("pc_jump", 1, 2);
   endtask

   task automatic test_halt_reset();
      rec_t r;
      r = base_rec(); r.halt = 1; step(r);
      expect_now("halt_self", 0, 0);
      r = base_rec(); step(r);
      expect_now("after_halt", 1, 7);
      test_reset();
      r = base_rec(); r.order = 64'd100; step(r);
      expect_now("post_reset", 0, 0);
      checks++;
      if (err_sticky !== 1'b0) begin failures++; $display("FAIL post_reset_sticky got=%b want=0", err_sticky); end
   endtask

   task automatic test_back_to_back();
      rec_t r;
      bit [3:0] lm [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
      test_reset();
      for (int i = 0; i < 300; i++) begin
         r = base_rec();
         r.valid = ($urandom_range(9) < 7);
         if (!r.valid) r.order = {$urandom(), $urandom()};
         r.rs1 = 5'($urandom_range(31)); r.rs2 = 5'($urandom_range(31)); r.rd = 5'($urandom_range(31));
         r.rs1d = (r.rs1 == 0) ? 0 : (m_known[r.rs1] ? m_reg[r.rs1] : $urandom());
         r.rs2d = (r.rs2 == 0) ? 0 : (m_known[r.rs2] ? m_reg[r.rs2] : $urandom());
         if ($urandom_range(15) == 0) r.rs1d ^= 32'h1 << $urandom_range(31);
         if ($urandom_range(15) == 0) r.rs2d ^= 32'h1 << $urandom_range(31);
         r.rdw = (r.rd == 0) ? (($urandom_range(15) == 0) ? 32'h1 : 32'h0) : $urandom();
         r.addr = $urandom() & 32'hFFFF_FFFC;
         case ($urandom_range(3))
            0: ;
            1: r.rm = lm[$urandom_range(6)];
            2: r.wm = lm[$urandom_range(6)];
            default: begin r.rm = 4'($urandom()); r.wm = 4'($urandom()); end
         endcase
         if ($urandom_range(15) == 0) r.addr[1:0] = 2'($urandom_range(3));
         r.trap = ($urandom_range(9) == 0);
         r.intr = ($urandom_range(9) == 0);
         if (r.intr || $urandom_range(19) == 0) r.pcr = $urandom() & 32'hFFFF_FFFC;
         r.pcw = r.pcr + 4;
         if ($urandom_range(19) == 0) r.order += 64'd2;
         step(r);
      end
   endtask

   initial begin
      resetn = 0; rvfi_valid = 0;
      @(negedge clk);
      test_reset();
      test_clean_chain();
      test_order_gap();
      test_shadow();
      test_rd_mem();
      test_intr_pc();
      test_halt_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/picorv32_rvfimon.md
Name: picorv32_rvfimon

Overview:
- Simulation and formal monitor attached to the RVFI retirement port of picorv32_axi.
- Checks every retired-instruction record for self-consistency: order sequence, PC continuity, register-file coherence, x0 rules, memory mask legality and post-halt silence.
- Reports each violation on registered error outputs and, optionally, stops simulation.
- Pure observer: it never drives the core.

Parameters:
- STOP_ON_ERROR, 1: when 1, on the first violation print "RVFI ERROR code=<n> order=<o> pc=<pc>" and call $stop; when 0, only drive the outputs.
- CHECK_MEM, 1: enable the memory-mask and alignment check (code 6).

Ports:
- clk  in  1  rising-edge clock shared with the core.
- resetn  in  1  synchronous active-low reset.
- rvfi_valid  in  1  one instruction retires this cycle.
- rvfi_order  in  64  retirement sequence number.
- rvfi_insn  in  32  instruction word (informational only).
- rvfi_trap, rvfi_halt, rvfi_intr  in  1 each  trap flag, halt flag, first instruction of an IRQ handler.
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  in  5 each  register indices.
- rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  in  32 each  register values.
- rvfi_pc_rdata, rvfi_pc_wdata  in  32 each  current PC and next PC.
- rvfi_mem_addr  in  32  memory address.
- rvfi_mem_rmask, rvfi_mem_wmask  in  4 each  byte-lane masks.
- rvfi_mem_rdata, rvfi_mem_wdata  in  32 each  memory data.
- err_valid  out  1  one-cycle pulse marking a violation.
- err_code  out  3  code of the reported violation.
- err_order  out  64  rvfi_order of the offending record.
- err_sticky  out  1  set on the first violation, held until reset.

Behaviour:
- Reset (resetn=0 at a rising edge): all outputs 0; every shadow-register valid bit cleared; have_prev=0; halted=0.
- Records are sampled only when rvfi_valid=1 at a rising edge. All other inputs are ignored while rvfi_valid=0.
- Results are registered: err_* reflect record N on the cycle after it is sampled.
- Checks, with error codes:
  - 1 ORDER: if have_prev, rvfi_order must equal prev_order+1 (64-bit wrap allowed). The first record after reset accepts any order.
  - 2 PC: if have_prev and rvfi_intr=0, rvfi_pc_rdata must equal prev_pc_wdata. When rvfi_intr=1 the check is skipped.
  - 3 RS1: if rs1_addr=0, rs1_rdata must be 0. Otherwise, if the shadow entry is valid, rs1_rdata must equal shadow[rs1_addr].
  - 4 RS2: same rule as RS1, applied to rs2.
  - 5 RD: if rd_addr=0, rd_wdata must be 0.
  - 6 MEM: the rmask and wmask must not both be nonzero. Each nonzero mask must be one of 0001, 0010, 0100, 1000, 0011, 1100, 1111. When any mask is nonzero, mem_addr[1:0] must be 00.
  - 7 HALT: any valid record after a record with rvfi_halt=1 is an error.
- Checks on a record with rvfi_trap=1:
  - Still applied: 1, 2, 7.
  - Skipped: 3–6.
  - That record performs no shadow update.
- Multiple violations in one record: report the lowest code. err_order is the offending record's order.
- Shadow update, on a valid record with trap=0 and rd_addr≠0:
  - shadow[rd_addr] <= rd_wdata; valid bit set.
  - The read-check of a record uses the shadow state from before that record's own write (read-before-write).
- State update on every valid record:
  - prev_order <= rvfi_order; prev_pc_wdata <= rvfi_pc_wdata; have_prev <= 1.
  - halted <= 1 if rvfi_halt=1.
- Reset mid-run discards all history; the next record is treated as first.
- err_sticky never clears except on reset. Later errors still pulse err_valid and update err_code/err_order.

Decomposition:
- Package picorv32_rvfimon_pkg holds the error-code constants (ERR_ORDER=1 … ERR_HALT=7) and the legal-mask list.
- One sub-module, picorv32_rvfimon_shadow_regs: 31×32 storage plus 32 valid bits, two combinational read ports (rs1, rs2) returning {valid, data}, one synchronous write port. x0 is hard-wired {valid=1, data=0}.

Test Plan:
- Reset, then orders 0,1,2 with pc chain 0x0→0x4→0x8 (each pc_rdata equals the previous pc_wdata) -> err_valid never asserted, err_sticky=0.
- Order 5 then order 7 -> err_valid=1 with err_code=1 and err_order=7, one cycle after the second record; err_sticky=1.
- Write x5=0xDEADBEEF, then a record with rs1_addr=5 and rs1_rdata=0x12345678 -> err_code=3. Repeat with rs1_rdata=0xDEADBEEF -> no error.
- rd_addr=0 with rd_wdata=0x1 -> err_code=5. A separate record with rmask=0101 -> err_code=6. A separate record with wmask=1111 and mem_addr=0x102 -> err_code=6.
- pc discontinuity with rvfi_intr=1 -> no error. The same discontinuity with rvfi_intr=0 -> err_code=2.
- A record with rvfi_halt=1, then any valid record -> err_code=7. Assert resetn=0 for one cycle, then send order 100 -> no error and err_sticky=0.
